vvp_sched: RTL and testbench
============================

VVP_SCHED -- requirements
Module: vvp_sched

Interface
REQ-001 SHALL have parameter N, default 64; vector width of the controlled vvp datapath.
REQ-002 SHALL have parameter LAT, default 3; vvp pipeline latency in cycles, from plane issue to valid partial sum; legal range 0..7.
REQ-003 SHALL have parameter ACCW, default 16; accumulator and result width.
REQ-004 SHALL have parameter SW = $clog2(N)+2; partial-sum width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  job request; sampled only when busy=0.
REQ-008 cfg_mode  input  2  vvp mode for the job.
REQ-009 wprec  input  3  weight bit-planes minus 1.
REQ-010 dprec  input  3  data bit-planes minus 1.
REQ-011 dsigned  input  1  data is two's complement; MSB data plane carries negative weight.
REQ-012 busy  output  1  job in progress or result pending.
REQ-013 vvp_mode  output  2  mode driven to vvp; job's latched cfg_mode.
REQ-014 iss_valid  output  1  a plane pair is presented to vvp this cycle.
REQ-015 w_idx  output  3  weight plane index of the issued pair.
REQ-016 d_idx  output  3  data plane index of the issued pair.
REQ-017 s_in  input  SW signed  vvp partial sum, valid LAT cycles after the matching issue.
REQ-018 res_valid  output  1  result available.
REQ-019 res_ready  input  1  result consumed when res_valid and res_ready are both high.
REQ-020 result  output  ACCW signed  accumulated dot product.

Function
REQ-021 States: IDLE, ISSUE, DRAIN, DONE.
REQ-022 IDLE with start=1: latch cfg_mode, wprec, dprec and dsigned; clear accumulator; busy=1 next cycle; next state ISSUE.
REQ-023 start while busy=1 is ignored; the running job and its latched config are unaffected.
REQ-024 ISSUE: iss_valid=1 for exactly P=(wprec+1)*(dprec+1) consecutive cycles.
REQ-025 Issue order: d_idx increments fastest, 0..dprec; at wrap, w_idx increments, 0..wprec; both start at 0.
REQ-026 After the last issue, next state is DRAIN.
REQ-027 Each issue pushes a tag {valid, shift=w_idx+d_idx, neg=dsigned AND d_idx==dprec} into a LAT-deep shift register; LAT=0 means the tag applies the same cycle.
REQ-028 Accumulate on the edge where the tag emerges valid: acc <= acc + (neg ? -(s_in<<shift) : (s_in<<shift)).
REQ-029 The term is computed at SW+14 bits, then truncated (wrap) to ACCW.
REQ-030 DRAIN: leave to DONE once the tag pipeline is empty.
REQ-031 Latency: start accepted at edge t0 -> res_valid=1 in cycle t0+P+LAT+1.
REQ-032 DONE: res_valid=1 and result holds acc, stable until the handshake.
REQ-033 On the handshake: next state IDLE, busy=0, res_valid=0 next cycle.
REQ-034 With res_ready held low, DONE persists indefinitely with no change to any output.
REQ-035 iss_valid=0 in IDLE, DRAIN and DONE; w_idx and d_idx hold their last value there.
REQ-036 vvp_mode holds the latched value until the next accepted start.

Reset
REQ-037 rst=1 at an edge forces IDLE, clears the tag pipeline and acc, and sets busy=0, iss_valid=0, res_valid=0, result=0, w_idx=0, d_idx=0, vvp_mode=0.
REQ-038 Reset mid-job abandons the job; s_in arriving afterwards is ignored.
REQ-039 rst has priority over start.

Configuration
REQ-040 Macro VVP_SCHED_SAT_EN.
REQ-041 With VVP_SCHED_SAT_EN defined, each accumulate saturates to [-2^(ACCW-1), 2^(ACCW-1)-1].
REQ-042 Without VVP_SCHED_SAT_EN, each accumulate wraps modulo 2^ACCW.

Verification
REQ-043 wprec=0, dprec=0, s_in=64, start at t0 -> one issue (0,0) at cycle t0+1; result=64 with res_valid at cycle t0+5.
REQ-044 wprec=1, dprec=1, dsigned=0, s_in=1 -> issue order (0,0),(0,1),(1,0),(1,1); result=9.
REQ-045 Same job as REQ-044 with dsigned=1 -> result=-3.
REQ-046 res_ready low 5 cycles while start pulses -> res_valid and result stable, no new issue; handshake -> busy=0 next cycle.
REQ-047 rst pulsed during the 2nd ISSUE cycle -> next cycle iss_valid=0, busy=0, res_valid=0; a fresh job then completes correctly.
REQ-048 wprec=7, dprec=7, s_in=64, ACCW=16 -> result=32767 with VVP_SCHED_SAT_EN; result=-32704 without.

Source files
------------

// File: rtl/vvp_sched_if.sv
// vvp_sched_if: job, vvp issue/partial-sum and result signals of the vvp_sched bit-plane scheduler.
interface vvp_sched_if #(
    parameter int SW = 8,
    parameter int ACCW = 16
);
    logic start;
    logic [1:0] cfg_mode;
    logic [2:0] wprec;
    logic [2:0] dprec;
    logic dsigned;
    logic busy;
    logic [1:0] vvp_mode;
    logic iss_valid;
    logic [2:0] w_idx;
    logic [2:0] d_idx;
    logic signed [SW-1:0] s_in;
    logic res_valid;
    logic res_ready;
    logic signed [ACCW-1:0] result;
    modport master (
        output start, cfg_mode, wprec, dprec, dsigned, s_in, res_ready,
        input busy, vvp_mode, iss_valid, w_idx, d_idx, res_valid, result
    );
    modport slave (
        input start, cfg_mode, wprec, dprec, dsigned, s_in, res_ready,
        output busy, vvp_mode, iss_valid, w_idx, d_idx, res_valid, result
    );
endinterface

// File: rtl/vvp_sched.sv
// vvp_sched: issues weight/data bit-plane pairs to a vvp and shift-accumulates the returning partial sums.
// Define VVP_SCHED_SAT_EN to saturate each accumulate instead of wrapping modulo 2^ACCW.
module vvp_sched #(
    parameter int N = 64,
    parameter int LAT = 3,
    parameter int ACCW = 16,
    parameter int SW = $clog2(N) + 2
) (
    input logic clk,
    input logic rst,
    vvp_sched_if.slave bus
);
    localparam int D = (LAT > 0) ? LAT : 1;
    localparam int TW = SW + 14;
    localparam int XW = ((TW > ACCW) ? TW : ACCW) + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [1:0] mode_q;
    logic [2:0] wp_q, dp_q, w_q, d_q;
    logic sgn_q;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [D-1:0] tv_q, tn_q;
    logic [D-1:0][3:0] ts_q;
    logic accept, last, wrap_d, cur_v, cur_n, pend, e_v, e_n;
    logic [3:0] cur_s, e_s;
    logic signed [TW-1:0] mag, term;
    logic signed [XW-1:0] sum;

    assign accept = state_q == IDLE && bus.start;
    assign cur_v = state_q == ISSUE;
    assign wrap_d = d_q == dp_q;
    assign last = wrap_d && w_q == wp_q;
    assign cur_s = {1'b0, w_q} + {1'b0, d_q};
    assign cur_n = sgn_q && wrap_d;
    // With LAT=0 the tag of the pair issued this cycle is applied at this very edge.
    assign e_v = (LAT == 0) ? cur_v : tv_q[D-1];
    assign e_n = (LAT == 0) ? cur_n : tn_q[D-1];
    assign e_s = (LAT == 0) ? cur_s : ts_q[D-1];

    // Tags still in flight after this edge, excluding the one being consumed now.
    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < LAT - 1; i++) pend = pend | tv_q[i];
    end

    assign mag = TW'(bus.s_in) <<< e_s;
    assign term = e_n ? -mag : mag;
    assign sum = XW'(acc_q) + XW'(term);

`ifdef VVP_SCHED_SAT_EN
    localparam logic signed [XW-1:0] MAXV = {{(XW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = ~MAXV;
    assign acc_d = (sum > MAXV) ? ACCW'(MAXV) : (sum < MINV) ? ACCW'(MINV) : sum[ACCW-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^sum[XW-1:ACCW];
    assign acc_d = sum[ACCW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && bus.start) state_d = ISSUE;
        if (state_q == ISSUE && last) state_d = (LAT == 0) ? DONE : DRAIN;
        if (state_q == DRAIN && !pend) state_d = DONE;
        if (state_q == DONE && bus.res_ready) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= '0;
            wp_q <= '0;
            dp_q <= '0;
            sgn_q <= 1'b0;
            w_q <= '0;
            d_q <= '0;
            acc_q <= '0;
            tv_q <= '0;
            tn_q <= '0;
            ts_q <= '0;
        end else begin
            if (accept) begin
                mode_q <= bus.cfg_mode;
                wp_q <= bus.wprec;
                dp_q <= bus.dprec;
                sgn_q <= bus.dsigned;
                w_q <= '0;
                d_q <= '0;
                acc_q <= '0;
            end else begin
                if (cur_v && !last) begin
                    d_q <= wrap_d ? 3'd0 : d_q + 3'd1;
                    w_q <= wrap_d ? w_q + 3'd1 : w_q;
                end
                if (e_v) acc_q <= acc_d;
            end
            for (int i = D - 1; i > 0; i--) begin
                tv_q[i] <= tv_q[i-1];
                tn_q[i] <= tn_q[i-1];
                ts_q[i] <= ts_q[i-1];
            end
            tv_q[0] <= cur_v;
            tn_q[0] <= cur_n;
            ts_q[0] <= cur_s;
        end
    end

    assign bus.busy = state_q != IDLE;
    assign bus.iss_valid = cur_v;
    assign bus.res_valid = state_q == DONE;
    assign bus.vvp_mode = mode_q;
    assign bus.w_idx = w_q;
    assign bus.d_idx = d_q;
    assign bus.result = acc_q;
endmodule

// File: tb/tb_vvp_sched.sv
// tb_vvp_sched: table vectors, random jobs against a plane-sum reference model, and reset/backpressure sequences.
module tb_vvp_sched;
    localparam int LAT = 3;
    localparam int ACCW = 16;
    localparam int SW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic signed [SW-1:0] sarr [8][8];

    vvp_sched_if #(.SW(SW), .ACCW(ACCW)) bus ();
    vvp_sched #(.N(64), .LAT(LAT), .ACCW(ACCW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int wp;
        int dp;
        bit sg;
        logic [1:0] md;
        int s;
        longint res;
        int hold;
    } vec_t;
    vec_t tbl [6];

    function automatic void chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    // Dot product of the bit planes: plane pair (w,d) weighs 2^(w+d), MSB data plane negative if signed.
    function automatic longint model(input int wp, input int dp, input bit sg);
        longint acc = 0;
        logic signed [ACCW-1:0] tr;
        for (int w = 0; w <= wp; w++)
            for (int d = 0; d <= dp; d++) begin
                longint t = longint'(sarr[w][d]) * (longint'(1) << (w + d));
                if (sg && d == dp) t = -t;
                acc = acc + t;
`ifdef VVP_SCHED_SAT_EN
                if (acc > 32767) acc = 32767;
                if (acc < -32768) acc = -32768;
`else
                tr = acc[ACCW-1:0];
                acc = longint'(tr);
`endif
            end
        return acc;
    endfunction

    task automatic run_job(input string nm, input int wp, input int dp, input bit sg,
                           input logic [1:0] md, input longint exp, input int hold);
        int p = (wp + 1) * (dp + 1);
        int k = 1;
        int n_iss = 0;
        int bad = 0;
        int hb = 0;
        int hist [$];
        longint r0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.wprec = 3'(wp);
        bus.dprec = 3'(dp);
        bus.dsigned = sg;
        bus.cfg_mode = md;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wprec = 3'($urandom);
        bus.dprec = 3'($urandom);
        bus.dsigned = 1'($urandom);
        bus.cfg_mode = 2'($urandom);
        while (k < 200) begin
            int e;
            if (bus.res_valid === 1'b1) break;
            if (bus.iss_valid !== (k <= p)) bad++;
            if (bus.busy !== 1'b1) bad++;
            if (bus.iss_valid === 1'b1) begin
                if (int'(bus.w_idx) != n_iss / (dp + 1) || int'(bus.d_idx) != n_iss % (dp + 1)) bad++;
                n_iss++;
                hist.push_back(int'(bus.w_idx) * 8 + int'(bus.d_idx));
            end else hist.push_back(-1);
            e = (hist.size() > LAT) ? hist[hist.size() - 1 - LAT] : -1;
            bus.s_in = (e >= 0) ? sarr[e / 8][e % 8] : SW'($urandom);
            @(negedge clk);
            k++;
        end
        chk({nm, " issue_errs"}, bad, 0);
        chk({nm, " n_issues"}, n_iss, p);
        chk({nm, " latency"}, k, p + LAT + 1);
        chk({nm, " result"}, longint'(bus.result), exp);
        chk({nm, " vvp_mode"}, bus.vvp_mode, md);
        chk({nm, " last_idx"}, int'(bus.w_idx) * 8 + int'(bus.d_idx), wp * 8 + dp);
        r0 = longint'(bus.result);
        for (int i = 0; i < hold; i++) begin
            bus.start = ~i[0];
            bus.cfg_mode = ~md;
            bus.s_in = SW'($urandom);
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || longint'(bus.result) != r0 || bus.iss_valid !== 1'b0 ||
                bus.busy !== 1'b1 || bus.vvp_mode !== md) hb++;
        end
        if (hold > 0) chk({nm, " hold_errs"}, hb, 0);
        bus.start = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk({nm, " busy_after"}, bus.busy, 0);
        chk({nm, " rvalid_after"}, bus.res_valid, 0);
        chk({nm, " mode_after"}, bus.vvp_mode, md);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.cfg_mode = '0;
        bus.wprec = '0;
        bus.dprec = '0;
        bus.dsigned = 1'b0;
        bus.s_in = '0;
        bus.res_ready = 1'b0;
        tbl[0] = '{0, 0, 1'b0, 2'd1, 64, 64, 0};
        tbl[1] = '{1, 1, 1'b0, 2'd2, 1, 9, 5};
        tbl[2] = '{1, 1, 1'b1, 2'd3, 1, -3, 0};
        tbl[3] = '{2, 1, 1'b1, 2'd0, 3, -21, 1};
        tbl[4] = '{0, 2, 1'b1, 2'd1, -5, 5, 0};
`ifdef VVP_SCHED_SAT_EN
        tbl[5] = '{7, 7, 1'b0, 2'd2, 64, 32767, 2};
`else
        tbl[5] = '{7, 7, 1'b0, 2'd2, 64, -32704, 2};
`endif
        repeat (3) @(negedge clk);
        chk("rst busy", bus.busy, 0);
        chk("rst iss_valid", bus.iss_valid, 0);
        chk("rst res_valid", bus.res_valid, 0);
        chk("rst result", longint'(bus.result), 0);
        chk("rst idx", int'(bus.w_idx) * 8 + int'(bus.d_idx), 0);
        chk("rst vvp_mode", bus.vvp_mode, 0);
        rst = 1'b0;

        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 8; w++)
                for (int d = 0; d < 8; d++) sarr[w][d] = SW'(tbl[r].s);
            run_job($sformatf("vec%0d", r), tbl[r].wp, tbl[r].dp, tbl[r].sg, tbl[r].md, tbl[r].res, tbl[r].hold);
        end

        for (int r = 0; r < 12; r++) begin
            int wp = $urandom_range(0, 7);
            int dp = $urandom_range(0, 7);
            bit sg = 1'($urandom);
            for (int w = 0; w < 8; w++)
                for (int d = 0; d < 8; d++) sarr[w][d] = SW'($urandom);
            run_job($sformatf("rnd%0d", r), wp, dp, sg, 2'($urandom), model(wp, dp, sg), $urandom_range(0, 3));
        end

        // Reset during the second issue cycle abandons the job; late partial sums must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.wprec = 3'd3;
        bus.dprec = 3'd3;
        bus.cfg_mode = 2'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("midrst pre_iss", bus.iss_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst iss_valid", bus.iss_valid, 0);
        chk("midrst busy", bus.busy, 0);
        chk("midrst res_valid", bus.res_valid, 0);
        chk("midrst result", longint'(bus.result), 0);
        chk("midrst idx", int'(bus.w_idx) * 8 + int'(bus.d_idx), 0);
        chk("midrst vvp_mode", bus.vvp_mode, 0);
        begin
            int lb = 0;
            for (int i = 0; i < LAT + 2; i++) begin
                bus.s_in = SW'(37 + i);
                @(negedge clk);
                if (longint'(bus.result) != 0 || bus.busy !== 1'b0) lb++;
            end
            chk("midrst late_sin", lb, 0);
        end
        for (int w = 0; w < 8; w++)
            for (int d = 0; d < 8; d++) sarr[w][d] = SW'($urandom);
        run_job("postrst", 2, 3, 1'b1, 2'd1, model(2, 3, 1'b1), 0);

        // Reset and start at the same edge: reset wins.
        @(negedge clk);
        bus.start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;
        chk("rstprio busy", bus.busy, 0);
        @(negedge clk);
        chk("rstprio iss_valid", bus.iss_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
